// File: rtl/slc_mem_responder_if.sv
// CPU-side request/response bundle for slc_mem_responder.
// Handshake: the CPU raises Req (with We/MAR/MDR) and holds it until Ready is seen.
// Ready pulses for one cycle when the access completes. MDR_In is valid in that cycle.
// Busy stays high until Req has been dropped after Ready.
interface slc_mem_responder_if;
    logic        Req;
    logic        We;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] MDR_In;
    logic        Ready;
    logic        Busy;

    modport master (output Req, We, MAR, MDR, input MDR_In, Ready, Busy);
    modport slave  (input Req, We, MAR, MDR, output MDR_In, Ready, Busy);
endinterface

// File: rtl/slc_mem_responder.sv
// SLC-3 memory responder: multi-cycle access to synchronous RAM or the switch/hex I/O word.
// Optional macro MEMIO_BOUNDS_CHECK_EN flags and suppresses accesses above the RAM range.
module slc_mem_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                Clk,
    input  logic                Reset_n,
    slc_mem_responder_if.slave  bus,
    input  logic [15:0]         Switches,
    output logic [15:0]         HEX_Data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [15:0]         ram_wdata,
    output logic                ram_we,
    input  logic [15:0]         ram_rdata,
    output logic                Err,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2, REL = 2'd3} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;
    logic        capture;
    logic [15:0] a_addr;
    logic [15:0] a_data;
    logic        a_we;
    logic        is_io;
    logic        oob;

    assign is_io     = (a_addr == IO_ADDR);
    assign ram_addr  = a_addr[ADDR_W-1:0];
    assign ram_wdata = a_data;
    assign dbg_state = state;

`ifdef MEMIO_BOUNDS_CHECK_EN
    logic err_q;

    assign oob = !is_io && (a_addr[15:ADDR_W] != '0);
    assign Err = err_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q <= 1'b0;
        end else if (capture && oob) begin
            err_q <= 1'b1;
        end
    end
`else
    // Upper address bits are ignored: out-of-range addresses alias into RAM.
    assign oob = 1'b0;
    assign Err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Req) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: state_next = REL;
            REL: begin
                if (!bus.Req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter still holds its load value only in the first ACCESS cycle.
    assign ram_we    = (state == ACCESS) && (cnt == CNT_LOAD) && a_we && !is_io && !oob;
    assign bus.Ready = (state == DONE);
    assign bus.Busy  = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            a_addr     <= 16'h0000;
            a_data     <= 16'h0000;
            a_we       <= 1'b0;
            bus.MDR_In <= 16'h0000;
            HEX_Data   <= 16'h0000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                a_addr <= bus.MAR;
                a_data <= bus.MDR;
                a_we   <= bus.We;
            end
            if (capture) begin
                if (!a_we) begin
                    if (is_io)    bus.MDR_In <= Switches;
                    else if (oob) bus.MDR_In <= 16'h0000;
                    else          bus.MDR_In <= ram_rdata;
                end else if (is_io) begin
                    HEX_Data <= a_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_slc_mem_responder.sv
// Directed bench for slc_mem_responder: RAM/I-O accesses, held request, mid-access reset,
// out-of-range read, against a behavioural 1-cycle-latency RAM.
module tb_slc_mem_responder;
    localparam int ADDR_W      = 10;
    localparam int WAIT_STATES = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REL  = 2'd3;

    logic              clk;
    logic              Reset_n;
    logic [15:0]       Switches;
    logic [15:0]       HEX_Data;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              ram_we;
    logic [15:0]       ram_rdata;
    logic              Err;
    logic [1:0]        dbg_state;

    slc_mem_responder_if bus();

    slc_mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES), .IO_ADDR(16'hFFFF)) dut (
        .Clk       (clk),
        .Reset_n   (Reset_n),
        .bus       (bus),
        .Switches  (Switches),
        .HEX_Data  (HEX_Data),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .Err       (Err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model: unwritten words read as 16'hA000 + address ----------------
    logic [15:0] mem [int];

    function automatic logic [15:0] ram_peek(input int a);
        if (mem.exists(a)) return mem[a];
        return 16'hA000 + 16'(a);
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[int'(ram_addr)] = ram_wdata;
        ram_rdata <= ram_peek(int'(ram_addr));
    end

    // ---------------- event monitor ----------------
    int          ready_cnt;
    int          we_cnt;
    logic [ADDR_W-1:0] we_addr;

    initial begin
        ready_cnt = 0;
        we_cnt    = 0;
        we_addr   = '0;
    end

    always @(negedge clk) begin
        if (Reset_n) begin
            if (bus.Ready) ready_cnt++;
            if (ram_we) begin
                we_cnt++;
                we_addr = ram_addr;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Raises Req, disturbs MAR/MDR/We after acceptance, measures cycles to Ready.
    // Reads pop the expected MDR_In from exp_q at the Ready cycle.
    task automatic do_access(input logic we_i, input logic [15:0] addr, input logic [15:0] data,
                             input bit hold, output int lat);
        logic [15:0] exp_d;
        @(negedge clk);
        bus.Req = 1'b1;
        bus.We  = we_i;
        bus.MAR = addr;
        bus.MDR = data;
        @(posedge clk);
        #1;
        if (!hold) bus.Req = 1'b0;
        bus.MAR = 16'($urandom_range(0, 65535));
        bus.MDR = 16'($urandom_range(0, 65535));
        bus.We  = ~we_i;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Ready) break;
            lat++;
        end
        if (!we_i) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            check("read_data", {16'h0, bus.MDR_In}, {16'h0, exp_d});
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.Busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'h0, bus.Busy}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int rc0;
    int wc0;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        Reset_n  = 1'b0;
        bus.Req  = 1'b0;
        bus.We   = 1'b0;
        bus.MAR  = 16'h0;
        bus.MDR  = 16'h0;
        Switches = 16'h0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.Req  = 1'($urandom_range(0, 1));
            bus.We   = 1'($urandom_range(0, 1));
            bus.MAR  = 16'($urandom_range(0, 65535));
            bus.MDR  = 16'($urandom_range(0, 65535));
            Switches = 16'($urandom_range(0, 65535));
        end
        check("rst_mdr_in", {16'h0, bus.MDR_In}, 32'h0);
        check("rst_hex",    {16'h0, HEX_Data},   32'h0);
        check("rst_ready",  {31'h0, bus.Ready},  32'h0);
        check("rst_busy",   {31'h0, bus.Busy},   32'h0);
        check("rst_ram_we", {31'h0, ram_we},     32'h0);
        check("rst_err",    {31'h0, Err},        32'h0);
        check("rst_state",  {30'h0, dbg_state},  {30'h0, ST_IDLE});
        bus.Req = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;

        // RAM write 1234 -> 0005
        wc0 = we_cnt;
        do_access(1'b1, 16'h0005, 16'h1234, 1'b0, lat);
        check("wr_latency", lat, WAIT_STATES);
        wait_idle();
        check("wr_we_pulses", we_cnt - wc0, 1);
        check("wr_we_addr", {22'h0, we_addr}, 32'h5);
        check("wr_ram_word", {16'h0, ram_peek(5)}, 32'h1234);

        // RAM read 0005
        exp_q.push_back(16'h1234);
        do_access(1'b0, 16'h0005, 16'h0000, 1'b0, lat);
        check("rd_latency", lat, WAIT_STATES);
        wait_idle();
        check("rd_mdr_holds", {16'h0, bus.MDR_In}, 32'h1234);

        // I/O read of switches
        Switches = 16'h00AB;
        wc0 = we_cnt;
        exp_q.push_back(16'h00AB);
        do_access(1'b0, 16'hFFFF, 16'h0000, 1'b0, lat);
        check("io_rd_latency", lat, WAIT_STATES);
        wait_idle();
        check("io_rd_no_we", we_cnt - wc0, 0);

        // I/O write to hex register
        do_access(1'b1, 16'hFFFF, 16'hBEEF, 1'b0, lat);
        wait_idle();
        check("io_wr_hex", {16'h0, HEX_Data}, 32'hBEEF);
        check("io_wr_no_we", we_cnt - wc0, 0);
        check("io_wr_ram_3ff", {16'h0, ram_peek(16'h03FF)}, 32'hA3FF);
        check("io_wr_mdr_kept", {16'h0, bus.MDR_In}, 32'h00AB);

        // Held request: one Ready only, parked in REL until Req drops
        rc0 = ready_cnt;
        exp_q.push_back(16'h1234);
        do_access(1'b0, 16'h0005, 16'h0000, 1'b1, lat);
        repeat (20) @(negedge clk);
        check("held_one_ready", ready_cnt - rc0, 1);
        check("held_busy", {31'h0, bus.Busy}, 32'h1);
        check("held_state_rel", {30'h0, dbg_state}, {30'h0, ST_REL});
        bus.Req = 1'b0;
        wait_idle();
        exp_q.push_back(16'hA006);
        do_access(1'b0, 16'h0006, 16'h0000, 1'b0, lat);
        check("after_held_latency", lat, WAIT_STATES);
        wait_idle();

        // Reset during the first ACCESS cycle of a write
        rc0 = ready_cnt;
        @(negedge clk);
        bus.Req = 1'b1;
        bus.We  = 1'b1;
        bus.MAR = 16'h0010;
        bus.MDR = 16'h5555;
        @(posedge clk);
        #1;
        check("midrst_we_before", {31'h0, ram_we}, 32'h1);
        Reset_n = 1'b0;
        #1;
        check("midrst_we_dropped", {31'h0, ram_we}, 32'h0);
        check("midrst_state_idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        check("midrst_busy", {31'h0, bus.Busy}, 32'h0);
        bus.Req = 1'b0;
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_ready", ready_cnt - rc0, 0);
        check("midrst_hex_cleared", {16'h0, HEX_Data}, 32'h0);

        // Read just above the RAM range
        wc0 = we_cnt;
`ifdef MEMIO_BOUNDS_CHECK_EN
        exp_q.push_back(16'h0000);
        do_access(1'b0, 16'h0400, 16'h0000, 1'b0, lat);
        wait_idle();
        check("oob_err", {31'h0, Err}, 32'h1);
        exp_q.push_back(16'h1234);
        do_access(1'b0, 16'h0005, 16'h0000, 1'b0, lat);
        wait_idle();
        check("oob_err_sticky", {31'h0, Err}, 32'h1);
`else
        exp_q.push_back(16'hA000);
        do_access(1'b0, 16'h0400, 16'h0000, 1'b0, lat);
        wait_idle();
        check("alias_err_low", {31'h0, Err}, 32'h0);
`endif
        check("oob_no_we", we_cnt - wc0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
